// File: rtl/cga_pixel_fetch.sv
// CGA video RAM read client: on each character-slot strobe, fetches a byte pair
// (char/attr or two pixel bytes) and presents it to the serializer one slot later.
module cga_pixel_fetch #(
  parameter int ADDR_BITS = 14
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        slot_strobe_i,
  input  logic        disp_en_i,
  input  logic        gfx_mode_i,
  input  logic [13:0] crtc_ma_i,
  input  logic [4:0]  crtc_ra_i,
  output logic [18:0] pixel_addr_o,
  output logic        pixel_read_o,
  input  logic [7:0]  pixel_data_i,
  output logic [7:0]  byte0_o,
  output logic [7:0]  byte1_o,
  output logic        out_blank_o,
  output logic        out_load_o,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    CAP1 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] base_q, base_d;
  logic [13:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic [7:0]  pend0_q, pend0_d;
  logic [7:0]  pend1_q, pend1_d;
  logic        pend_blank_q, pend_blank_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        blank_q, blank_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic [13:0] base_s;
  logic        unused_s;

  // Only ma[12:0] (text) or ra[0]/ma[11:0] (graphics) reach the address.
  assign unused_s = ^{crtc_ra_i[4:1], crtc_ma_i[13]};

  // Address of the first byte of the slot, from the strobe-time inputs.
  always_comb begin
    if (gfx_mode_i) begin
      base_s = {crtc_ra_i[0], crtc_ma_i[11:0], 1'b0};
    end else begin
      base_s = {crtc_ma_i[12:0], 1'b0};
    end
  end

  // Next-state logic for the fetch FSM, pending pair and output buffer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    addr_d       = addr_q;
    read_d       = 1'b0;
    pend0_d      = pend0_q;
    pend1_d      = pend1_q;
    pend_blank_d = pend_blank_q;
    byte0_d      = byte0_q;
    byte1_d      = byte1_q;
    blank_d      = blank_q;
    load_d       = 1'b0;
    overrun_d    = overrun_q;

    // Every strobe publishes the previous slot's pair, even mid-fetch.
    if (slot_strobe_i) begin
      byte0_d = pend0_q;
      byte1_d = pend1_q;
      blank_d = pend_blank_q;
      load_d  = 1'b1;
      if (state_q != IDLE) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      load_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (slot_strobe_i && disp_en_i) begin
          base_d  = base_s;
          addr_d  = base_s;
          read_d  = 1'b1;
          state_d = RD0;
        end else if (slot_strobe_i) begin
          pend0_d      = 8'h00;
          pend1_d      = 8'h00;
          pend_blank_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RD0: begin
        addr_d  = base_q + 14'd1;
        read_d  = 1'b1;
        state_d = RD1;
      end
      RD1: begin
        pend0_d = pixel_data_i;
        state_d = CAP1;
      end
      CAP1: begin
        pend1_d      = pixel_data_i;
        pend_blank_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      base_q       <= 14'd0;
      addr_q       <= 14'd0;
      read_q       <= 1'b0;
      pend0_q      <= 8'h00;
      pend1_q      <= 8'h00;
      pend_blank_q <= 1'b1;
      byte0_q      <= 8'h00;
      byte1_q      <= 8'h00;
      blank_q      <= 1'b1;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      pend_blank_q <= pend_blank_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      blank_q      <= blank_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pixel_addr_o = 19'(addr_q[ADDR_BITS-1:0]);
  assign pixel_read_o = read_q;
  assign byte0_o      = byte0_q;
  assign byte1_o      = byte1_q;
  assign out_blank_o  = blank_q;
  assign out_load_o   = load_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_cga_pixel_fetch.sv
// Directed bench for cga_pixel_fetch: vector table of slots plus overrun and
// mid-fetch reset sequences against a behavioural 1-cycle-latency VRAM.
module tb_cga_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slot_strobe = 1'b0;
  logic        disp_en = 1'b0;
  logic        gfx_mode = 1'b0;
  logic [13:0] crtc_ma = 14'd0;
  logic [4:0]  crtc_ra = 5'd0;
  logic [18:0] pixel_addr;
  logic        pixel_read;
  logic [7:0]  pixel_data = 8'h00;
  logic [7:0]  byte0, byte1;
  logic        out_blank, out_load, busy, overrun;

  logic [7:0]  vram [0:16383];
  logic [18:0] rd_log [$];

  int n_pass = 0;
  int n_total = 0;

  cga_pixel_fetch #(.ADDR_BITS(14)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .slot_strobe_i(slot_strobe),
    .disp_en_i(disp_en), .gfx_mode_i(gfx_mode), .crtc_ma_i(crtc_ma),
    .crtc_ra_i(crtc_ra), .pixel_addr_o(pixel_addr), .pixel_read_o(pixel_read),
    .pixel_data_i(pixel_data), .byte0_o(byte0), .byte1_o(byte1),
    .out_blank_o(out_blank), .out_load_o(out_load), .busy_o(busy),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pixel_data <= vram[pixel_addr[13:0]];
    if (pixel_read) rd_log.push_back(pixel_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        disp;
    logic        gfx;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic [13:0] addr;
  } vec_t;

  vec_t vecs[8];

  // One slot: strobe, check published pair, count busy/load, check VRAM reads.
  task automatic run_slot(input vec_t v, input logic [7:0] e0, input logic [7:0] e1,
                          input logic eb, input string tag);
    int busy_cnt = 0;
    int load_cnt = 0;
    rd_log.delete();
    @(negedge clk);
    disp_en = v.disp; gfx_mode = v.gfx; crtc_ma = v.ma; crtc_ra = v.ra;
    slot_strobe = 1'b1;
    @(negedge clk);
    slot_strobe = 1'b0;
    gfx_mode = ~v.gfx; crtc_ma = ~v.ma; crtc_ra = ~v.ra; disp_en = ~v.disp;
    chk({tag, " byte0"}, 32'(byte0), 32'(e0));
    chk({tag, " byte1"}, 32'(byte1), 32'(e1));
    chk({tag, " out_blank"}, 32'(out_blank), 32'(eb));
    for (int k = 0; k < 8; k++) begin
      if (busy) busy_cnt++;
      if (out_load) load_cnt++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(busy_cnt), v.disp ? 32'd3 : 32'd0);
    chk({tag, " load pulses"}, 32'(load_cnt), 32'd1);
    if (v.disp) begin
      chk({tag, " read count"}, 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) begin
        chk({tag, " addr0"}, 32'(rd_log[0]), 32'(v.addr));
        chk({tag, " addr1"}, 32'(rd_log[1]), 32'(v.addr) + 32'd1);
      end
    end else begin
      chk({tag, " no reads"}, 32'(rd_log.size()), 32'd0);
    end
  endtask

  logic [7:0] p0, p1;
  logic       pb;
  vec_t       tmp;
  int         loads;

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'((i * 37) ^ (i >> 6));
    vram[14'h0246] = 8'h41;
    vram[14'h0247] = 8'h1F;

    vecs[0] = '{1'b1, 1'b0, 14'h0123, 5'd0, 14'h0246};
    vecs[1] = '{1'b1, 1'b1, 14'h0010, 5'd1, 14'h2020};
    vecs[2] = '{1'b1, 1'b0, 14'h1FFF, 5'd0, 14'h3FFE};
    vecs[3] = '{1'b1, 1'b1, 14'h0FFF, 5'd1, 14'h3FFE};
    vecs[4] = '{1'b0, 1'b0, 14'h0055, 5'd0, 14'h0000};
    vecs[5] = '{1'b1, 1'b0, 14'h2ABC, 5'd3, 14'h1578};
    vecs[6] = '{1'b1, 1'b1, 14'h37F0, 5'd2, 14'h0FE0};
    vecs[7] = '{1'b0, 1'b1, 14'h0000, 5'd0, 14'h0000};

    // Reset held two cycles with an active strobe that must be ignored.
    slot_strobe = 1'b1; disp_en = 1'b1;
    repeat (2) @(negedge clk);
    slot_strobe = 1'b0;
    chk("rst pixel_addr", 32'(pixel_addr), 32'd0);
    chk("rst pixel_read", 32'(pixel_read), 32'd0);
    chk("rst byte0", 32'(byte0), 32'd0);
    chk("rst byte1", 32'(byte1), 32'd0);
    chk("rst out_blank", 32'(out_blank), 32'd1);
    chk("rst out_load", 32'(out_load), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    p0 = 8'h00; p1 = 8'h00; pb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_slot(vecs[i], p0, p1, pb, $sformatf("vec%0d", i));
      if (vecs[i].disp) begin
        p0 = vram[vecs[i].addr];
        p1 = vram[vecs[i].addr + 14'd1];
        pb = 1'b0;
      end else begin
        p0 = 8'h00; p1 = 8'h00; pb = 1'b1;
      end
    end
    chk("no overrun after spaced slots", 32'(overrun), 32'd0);

    // Overrun: second strobe 2 clk after the first must not restart the fetch.
    rd_log.delete();
    @(negedge clk);
    disp_en = 1'b1; gfx_mode = 1'b0; crtc_ma = 14'h0123; crtc_ra = 5'd0;
    slot_strobe = 1'b1;
    @(negedge clk);
    slot_strobe = 1'b0;
    crtc_ma = 14'h0010;
    @(negedge clk);
    slot_strobe = 1'b1;
    @(negedge clk);
    slot_strobe = 1'b0;
    chk("ovr overrun set", 32'(overrun), 32'd1);
    chk("ovr second load", 32'(out_load), 32'd1);
    chk("ovr copy byte0", 32'(byte0), 32'd0);
    chk("ovr copy blank", 32'(out_blank), 32'd1);
    repeat (8) @(negedge clk);
    chk("ovr read count", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) chk("ovr addr0", 32'(rd_log[0]), 32'h0246);
    tmp = '{1'b0, 1'b0, 14'h0000, 5'd0, 14'h0000};
    run_slot(tmp, 8'h41, 8'h1F, 1'b0, "ovr deliver");
    chk("ovr sticky", 32'(overrun), 32'd1);

    // Reset during RD1 abandons the fetch and clears overrun.
    rd_log.delete();
    @(negedge clk);
    disp_en = 1'b1; gfx_mode = 1'b0; crtc_ma = 14'h0010; crtc_ra = 5'd0;
    slot_strobe = 1'b1;
    @(negedge clk);
    slot_strobe = 1'b0;
    @(negedge clk);
    chk("mid busy before rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid busy after rst", 32'(busy), 32'd0);
    chk("mid read after rst", 32'(pixel_read), 32'd0);
    chk("mid overrun cleared", 32'(overrun), 32'd0);
    loads = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_load) loads++;
      @(negedge clk);
    end
    chk("mid no load", 32'(loads), 32'd0);
    run_slot(tmp, 8'h00, 8'h00, 1'b1, "mid after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
